// File: rtl/id_ex_operand_stage_pkg.sv
// rtl/id_ex_operand_stage_pkg.sv - shared constants and bypass-select encoding for the ID/EX operand stage
package id_ex_operand_stage_pkg;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         CTRL_W_DEFAULT = 16;

  // Which source fed an operand; kept visible for waveform debug.
  typedef enum logic [1:0] {
    SEL_RF  = 2'd0,
    SEL_WB  = 2'd1,
    SEL_MEM = 2'd2,
    SEL_EX  = 2'd3
  } bypass_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_bypass_mux.sv
// rtl/id_ex_operand_stage_bypass_mux.sv - per-operand bypass selection, EX over MEM over WB over register file
module operand_bypass_mux
  import id_ex_operand_stage_pkg::*;
(
  input  logic [4:0]  src_i,
  input  logic [31:0] rf_data_i,
  input  logic        ex_en_i,
  input  logic [4:0]  ex_reg_i,
  input  logic [31:0] ex_data_i,
  input  logic        mem_en_i,
  input  logic [4:0]  mem_reg_i,
  input  logic [31:0] mem_data_i,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_reg_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] data_o,
  output bypass_sel_e sel_o
);

  always_comb begin
    sel_o  = SEL_RF;
    data_o = rf_data_i;
    // r0 is hardwired to zero, so no forwarding source may claim it.
    if (src_i == REG_ZERO) begin
      data_o = '0;
    end else if (ex_en_i && (ex_reg_i == src_i)) begin
      sel_o  = SEL_EX;
      data_o = ex_data_i;
    end else if (mem_en_i && (mem_reg_i == src_i)) begin
      sel_o  = SEL_MEM;
      data_o = mem_data_i;
    end else if (wb_en_i && (wb_reg_i == src_i)) begin
      sel_o  = SEL_WB;
      data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with operand bypass, load-use stall and bubble counter
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [4:0]        id_dst,
  input  logic              id_reg_w_en,
  input  logic              id_is_load,
  input  logic [31:0]       rf_data_a,
  input  logic [31:0]       rf_data_b,
  input  logic [31:0]       ex_fwd_data,
  input  logic              mem_fwd_w_en,
  input  logic [4:0]        mem_fwd_reg,
  input  logic [31:0]       mem_fwd_data,
  input  logic              wb_w_en,
  input  logic [4:0]        wb_req_w,
  input  logic [31:0]       wb_data_w,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_op_a,
  output logic [31:0]       ex_op_b,
  output logic [4:0]        ex_dst,
  output logic              ex_reg_w_en,
  output logic              ex_is_load,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              ex_valid_q,    ex_valid_d;
  logic [31:0]       ex_pc_q,       ex_pc_d;
  logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;
  logic [31:0]       ex_imm_q,      ex_imm_d;
  logic [31:0]       ex_op_a_q,     ex_op_a_d;
  logic [31:0]       ex_op_b_q,     ex_op_b_d;
  logic [4:0]        ex_dst_q,      ex_dst_d;
  logic              ex_reg_w_en_q, ex_reg_w_en_d;
  logic              ex_is_load_q,  ex_is_load_d;
  logic [CNT_W-1:0]  bubble_cnt_q,  bubble_cnt_d;

  logic        ex_fwd_en;
  logic [31:0] op_a, op_b;
  bypass_sel_e sel_a, sel_b;
  logic        lu;

  // Load results are not ready in EX; they reach ID only via MEM/WB.
  assign ex_fwd_en = ex_valid_q & ex_reg_w_en_q & ~ex_is_load_q;

  operand_bypass_mux u_bypass_a (
    .src_i      (id_rs),
    .rf_data_i  (rf_data_a),
    .ex_en_i    (ex_fwd_en),
    .ex_reg_i   (ex_dst_q),
    .ex_data_i  (ex_fwd_data),
    .mem_en_i   (mem_fwd_w_en),
    .mem_reg_i  (mem_fwd_reg),
    .mem_data_i (mem_fwd_data),
    .wb_en_i    (wb_w_en),
    .wb_reg_i   (wb_req_w),
    .wb_data_i  (wb_data_w),
    .data_o     (op_a),
    .sel_o      (sel_a)
  );

  operand_bypass_mux u_bypass_b (
    .src_i      (id_rt),
    .rf_data_i  (rf_data_b),
    .ex_en_i    (ex_fwd_en),
    .ex_reg_i   (ex_dst_q),
    .ex_data_i  (ex_fwd_data),
    .mem_en_i   (mem_fwd_w_en),
    .mem_reg_i  (mem_fwd_reg),
    .mem_data_i (mem_fwd_data),
    .wb_en_i    (wb_w_en),
    .wb_reg_i   (wb_req_w),
    .wb_data_i  (wb_data_w),
    .data_o     (op_b),
    .sel_o      (sel_b)
  );

  assign lu = ex_valid_q & ex_is_load_q & (ex_dst_q != REG_ZERO) & id_valid &
              ((id_uses_rs & (id_rs == ex_dst_q)) | (id_uses_rt & (id_rt == ex_dst_q)));

  // Under hold the upstream already freezes, so the stall is only raised when we bubble.
  assign id_stall = en & ~flush & ~hold & lu;

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_ctrl_d     = ex_ctrl_q;
    ex_imm_d      = ex_imm_q;
    ex_op_a_d     = ex_op_a_q;
    ex_op_b_d     = ex_op_b_q;
    ex_dst_d      = ex_dst_q;
    ex_reg_w_en_d = ex_reg_w_en_q;
    ex_is_load_d  = ex_is_load_q;
    bubble_cnt_d  = bubble_cnt_q;
    if (flush) begin
      ex_valid_d    = 1'b0;
      ex_reg_w_en_d = 1'b0;
      ex_is_load_d  = 1'b0;
    end else if (hold) begin
      ex_valid_d    = ex_valid_q;
    end else if (lu) begin
      ex_valid_d    = 1'b0;
      ex_reg_w_en_d = 1'b0;
      ex_is_load_d  = 1'b0;
      if (bubble_cnt_q != {CNT_W{1'b1}}) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end else begin
      ex_valid_d    = id_valid;
      ex_pc_d       = id_pc;
      ex_ctrl_d     = id_ctrl;
      ex_imm_d      = id_imm;
      ex_op_a_d     = op_a;
      ex_op_b_d     = op_b;
      ex_dst_d      = id_dst;
      ex_reg_w_en_d = id_valid & id_reg_w_en;
      ex_is_load_d  = id_valid & id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_ctrl_q     <= '0;
      ex_imm_q      <= '0;
      ex_op_a_q     <= '0;
      ex_op_b_q     <= '0;
      ex_dst_q      <= '0;
      ex_reg_w_en_q <= 1'b0;
      ex_is_load_q  <= 1'b0;
      bubble_cnt_q  <= '0;
    end else if (en) begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_imm_q      <= ex_imm_d;
      ex_op_a_q     <= ex_op_a_d;
      ex_op_b_q     <= ex_op_b_d;
      ex_dst_q      <= ex_dst_d;
      ex_reg_w_en_q <= ex_reg_w_en_d;
      ex_is_load_q  <= ex_is_load_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

  // Debug select codes must always agree with the data they claim to have picked.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((sel_a != SEL_EX) || (op_a == ex_fwd_data));
      assert ((sel_b != SEL_EX) || (op_b == ex_fwd_data));
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_imm      = ex_imm_q;
  assign ex_op_a     = ex_op_a_q;
  assign ex_op_b     = ex_op_b_q;
  assign ex_dst      = ex_dst_q;
  assign ex_reg_w_en = ex_reg_w_en_q;
  assign ex_is_load  = ex_is_load_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed vector table plus randomized reference-model check of id_ex_operand_stage
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, en, flush, hold, id_valid;
  logic [31:0] id_pc, id_imm;
  logic [15:0] id_ctrl;
  logic [4:0]  id_rs, id_rt, id_dst, mem_fwd_reg, wb_req_w;
  logic        id_uses_rs, id_uses_rt, id_reg_w_en, id_is_load, mem_fwd_w_en, wb_w_en;
  logic [31:0] rf_data_a, rf_data_b, ex_fwd_data, mem_fwd_data, wb_data_w;

  logic        id_stall, ex_valid, ex_reg_w_en, ex_is_load;
  logic [31:0] ex_pc, ex_imm, ex_op_a, ex_op_b;
  logic [15:0] ex_ctrl;
  logic [4:0]  ex_dst;
  logic [15:0] bubble_cnt;

  logic        id_stall2, ex_valid2, ex_reg_w_en2, ex_is_load2;
  logic [31:0] ex_pc2, ex_imm2, ex_op_a2, ex_op_b2;
  logic [15:0] ex_ctrl2;
  logic [4:0]  ex_dst2;
  logic [1:0]  bubble_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.CTRL_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .hold(hold), .id_valid(id_valid),
    .id_pc(id_pc), .id_ctrl(id_ctrl), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_w_en(id_reg_w_en), .id_is_load(id_is_load), .rf_data_a(rf_data_a),
    .rf_data_b(rf_data_b), .ex_fwd_data(ex_fwd_data), .mem_fwd_w_en(mem_fwd_w_en),
    .mem_fwd_reg(mem_fwd_reg), .mem_fwd_data(mem_fwd_data), .wb_w_en(wb_w_en),
    .wb_req_w(wb_req_w), .wb_data_w(wb_data_w), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_ctrl(ex_ctrl), .ex_imm(ex_imm), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_dst(ex_dst), .ex_reg_w_en(ex_reg_w_en), .ex_is_load(ex_is_load), .bubble_cnt(bubble_cnt)
  );

  id_ex_operand_stage #(.CTRL_W(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .hold(hold), .id_valid(id_valid),
    .id_pc(id_pc), .id_ctrl(id_ctrl), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_w_en(id_reg_w_en), .id_is_load(id_is_load), .rf_data_a(rf_data_a),
    .rf_data_b(rf_data_b), .ex_fwd_data(ex_fwd_data), .mem_fwd_w_en(mem_fwd_w_en),
    .mem_fwd_reg(mem_fwd_reg), .mem_fwd_data(mem_fwd_data), .wb_w_en(wb_w_en),
    .wb_req_w(wb_req_w), .wb_data_w(wb_data_w), .id_stall(id_stall2), .ex_valid(ex_valid2),
    .ex_pc(ex_pc2), .ex_ctrl(ex_ctrl2), .ex_imm(ex_imm2), .ex_op_a(ex_op_a2), .ex_op_b(ex_op_b2),
    .ex_dst(ex_dst2), .ex_reg_w_en(ex_reg_w_en2), .ex_is_load(ex_is_load2), .bubble_cnt(bubble_cnt2)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit r, e, f, h, iv;
    logic [4:0] rs, rt;
    bit urs, urt;
    logic [4:0] dst;
    bit w, ld, mw;
    logic [4:0] mr;
    logic [31:0] md;
    bit ww;
    logic [4:0] wr;
    bit es, ev, co;
    logic [31:0] ea, eb;
    int ec;
  } vec_t;

  function automatic vec_t v(input bit r, e, f, h, iv, input logic [4:0] rs, rt,
                             input bit urs, urt, input logic [4:0] dst, input bit w, ld, mw,
                             input logic [4:0] mr, input logic [31:0] md, input bit ww,
                             input logic [4:0] wr, input bit es, ev, co,
                             input logic [31:0] ea, eb, input int ec);
    vec_t t;
    t.r = r; t.e = e; t.f = f; t.h = h; t.iv = iv; t.rs = rs; t.rt = rt;
    t.urs = urs; t.urt = urt; t.dst = dst; t.w = w; t.ld = ld; t.mw = mw; t.mr = mr;
    t.md = md; t.ww = ww; t.wr = wr; t.es = es; t.ev = ev; t.co = co;
    t.ea = ea; t.eb = eb; t.ec = ec;
    return t;
  endfunction

  // Reference model of the EX-side contents.
  typedef struct {
    bit v;
    logic [31:0] pc;
    logic [15:0] ctrl;
    logic [31:0] imm, a, b;
    logic [4:0] dst;
    bit w, ld;
    int cnt;
  } mstate_t;

  mstate_t m;

  function automatic logic [31:0] resolve(input logic [4:0] src, input logic [31:0] rf);
    if (src == 5'd0) return 32'd0;
    if (m.v && m.w && !m.ld && m.dst == src) return ex_fwd_data;
    if (mem_fwd_w_en && mem_fwd_reg == src) return mem_fwd_data;
    if (wb_w_en && wb_req_w == src) return wb_data_w;
    return rf;
  endfunction

  vec_t tv[28];

  initial begin
    mstate_t nx;
    bit lu, exp_stall;
    int c16, c2;

    //          r e f h iv rs rt ur ut dst w ld mw mr md            ww wr es ev co ea            eb            ec
    tv[0]  = v(1,1,0,0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h0,        32'h0,        0);
    tv[1]  = v(0,1,0,0, 1, 3, 0, 1, 1, 3, 1, 0, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'h44,       32'h0,        0);
    tv[2]  = v(0,1,0,0, 1, 3, 0, 1, 1, 3, 1, 0, 1, 3, 32'h22,       1, 3, 0, 1, 1, 32'h11,       32'h0,        0);
    tv[3]  = v(0,1,0,0, 1, 3, 0, 1, 1, 7, 1, 0, 1, 3, 32'h22,       1, 3, 0, 1, 1, 32'h11,       32'h0,        0);
    tv[4]  = v(0,1,0,0, 1, 3, 0, 1, 1, 7, 1, 0, 1, 3, 32'h22,       1, 3, 0, 1, 1, 32'h22,       32'h0,        0);
    tv[5]  = v(0,1,0,0, 1, 3, 0, 1, 1, 7, 1, 0, 0, 3, 32'h22,       1, 3, 0, 1, 1, 32'h33,       32'h0,        0);
    tv[6]  = v(0,1,0,0, 1, 3, 0, 1, 1, 0, 1, 0, 0, 3, 32'h22,       0, 3, 0, 1, 1, 32'h44,       32'h0,        0);
    tv[7]  = v(0,1,0,0, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 32'h22,       1, 0, 0, 1, 1, 32'h0,        32'h0,        0);
    tv[8]  = v(0,1,0,0, 1, 0, 0, 1, 1, 5, 1, 1, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'h0,        32'h0,        0);
    tv[9]  = v(0,1,0,0, 1, 1, 5, 1, 1, 6, 1, 0, 0, 0, 32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h0,        1);
    tv[10] = v(0,1,0,0, 1, 1, 5, 1, 1, 6, 1, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 1, 32'h44,       32'hDEADBEEF, 1);
    tv[11] = v(0,1,0,0, 1, 0, 0, 1, 1, 5, 1, 1, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'h0,        32'h0,        1);
    tv[12] = v(0,1,0,0, 1, 1, 5, 1, 0, 0, 1, 1, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'h44,       32'h55,       1);
    tv[13] = v(0,1,0,0, 1, 0, 0, 1, 1, 5, 1, 1, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'h0,        32'h0,        1);
    tv[14] = v(0,1,1,1, 1, 1, 5, 1, 1, 6, 1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        1);
    tv[15] = v(0,1,0,0, 1, 1, 2, 1, 1, 9, 1, 0, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'h44,       32'h55,       1);
    tv[16] = v(0,1,0,1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'h44,       32'h55,       1);
    tv[17] = v(0,1,0,0, 1, 1, 2, 1, 1, 5, 1, 1, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'h44,       32'h55,       1);
    tv[18] = v(0,0,0,0, 1, 0, 5, 1, 1, 6, 1, 0, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'h44,       32'h55,       1);
    tv[19] = v(0,1,0,0, 1, 0, 5, 1, 1, 6, 1, 0, 0, 0, 32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h0,        2);
    tv[20] = v(0,1,0,0, 1, 0, 0, 1, 1, 5, 1, 1, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'h0,        32'h0,        2);
    tv[21] = v(0,1,0,0, 1, 0, 5, 0, 1, 6, 1, 0, 0, 0, 32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h0,        3);
    tv[22] = v(0,1,0,0, 1, 0, 0, 1, 1, 5, 1, 1, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'h0,        32'h0,        3);
    tv[23] = v(0,1,0,0, 1, 0, 5, 0, 1, 6, 1, 0, 0, 0, 32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h0,        4);
    tv[24] = v(0,1,0,0, 1, 0, 0, 1, 1, 5, 1, 1, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'h0,        32'h0,        4);
    tv[25] = v(0,1,0,0, 1, 0, 5, 0, 1, 6, 1, 0, 0, 0, 32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h0,        5);
    tv[26] = v(0,1,0,0, 1, 1, 2, 1, 1, 9, 1, 0, 0, 0, 32'h0,        0, 0, 0, 1, 1, 32'h44,       32'h55,       5);
    tv[27] = v(1,1,0,0, 1, 1, 5, 1, 1, 9, 1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h0,        32'h0,        0);

    rf_data_a = 32'h44; rf_data_b = 32'h55; ex_fwd_data = 32'h11; wb_data_w = 32'h33;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      rst = tv[i].r; en = tv[i].e; flush = tv[i].f; hold = tv[i].h; id_valid = tv[i].iv;
      id_rs = tv[i].rs; id_rt = tv[i].rt; id_uses_rs = tv[i].urs; id_uses_rt = tv[i].urt;
      id_dst = tv[i].dst; id_reg_w_en = tv[i].w; id_is_load = tv[i].ld;
      mem_fwd_w_en = tv[i].mw; mem_fwd_reg = tv[i].mr; mem_fwd_data = tv[i].md;
      wb_w_en = tv[i].ww; wb_req_w = tv[i].wr;
      id_pc = 32'h1000 + 32'(4 * i); id_imm = 32'(i); id_ctrl = 16'(i + 1);
      #1;
      if (i > 0) chk($sformatf("v%0d id_stall", i), 128'(id_stall), 128'(tv[i].es));
      @(posedge clk); #1;
      chk($sformatf("v%0d ex_valid", i), 128'(ex_valid), 128'(tv[i].ev));
      chk($sformatf("v%0d bubble_cnt", i), 128'(bubble_cnt), 128'(tv[i].ec));
      chk($sformatf("v%0d bubble_cnt_w2", i), 128'(bubble_cnt2), 128'(tv[i].ec > 3 ? 3 : tv[i].ec));
      if (tv[i].co) begin
        chk($sformatf("v%0d ex_op_a", i), 128'(ex_op_a), 128'(tv[i].ea));
        chk($sformatf("v%0d ex_op_b", i), 128'(ex_op_b), 128'(tv[i].eb));
      end
      if (tv[i].r) begin
        chk($sformatf("v%0d reset fields", i),
            128'({ex_pc, ex_ctrl, ex_imm, ex_dst, ex_reg_w_en, ex_is_load, id_stall}), 128'(0));
      end else if (tv[i].e && !tv[i].f && !tv[i].h && !tv[i].es) begin
        chk($sformatf("v%0d capture fields", i),
            128'({ex_pc, ex_ctrl, ex_imm, ex_dst, ex_reg_w_en, ex_is_load}),
            128'({id_pc, id_ctrl, id_imm, id_dst, tv[i].iv & tv[i].w, tv[i].iv & tv[i].ld}));
      end
    end

    // Randomized phase; the last table row was a reset, so the model starts cleared.
    m = '{default: 0};
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 9) == 0);
      hold = ($urandom_range(0, 9) == 0);
      id_valid = ($urandom_range(0, 4) != 0);
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      id_dst = 5'($urandom_range(0, 7)); id_reg_w_en = 1'($urandom);
      id_is_load = ($urandom_range(0, 2) == 0);
      id_pc = $urandom; id_imm = $urandom; id_ctrl = 16'($urandom);
      rf_data_a = $urandom; rf_data_b = $urandom; ex_fwd_data = $urandom;
      mem_fwd_w_en = 1'($urandom); mem_fwd_reg = 5'($urandom_range(0, 7)); mem_fwd_data = $urandom;
      wb_w_en = 1'($urandom); wb_req_w = 5'($urandom_range(0, 7)); wb_data_w = $urandom;
      #1;
      lu = m.v && m.ld && (m.dst != 0) && id_valid &&
           ((id_uses_rs && id_rs == m.dst) || (id_uses_rt && id_rt == m.dst));
      exp_stall = en && !flush && !hold && lu;
      nx = m;
      if (rst) begin
        nx = '{default: 0};
      end else if (en) begin
        if (flush || (!hold && lu)) begin
          nx.v = 0; nx.w = 0; nx.ld = 0;
          if (!flush) nx.cnt = m.cnt + 1;
        end else if (!hold) begin
          nx.v = id_valid; nx.pc = id_pc; nx.ctrl = id_ctrl; nx.imm = id_imm;
          nx.a = resolve(id_rs, rf_data_a); nx.b = resolve(id_rt, rf_data_b);
          nx.dst = id_dst; nx.w = id_valid && id_reg_w_en; nx.ld = id_valid && id_is_load;
        end
      end
      chk("rnd id_stall", 128'({id_stall, id_stall2}), 128'({exp_stall, exp_stall}));
      @(posedge clk); #1;
      m = nx;
      c16 = m.cnt > 65535 ? 65535 : m.cnt;
      c2 = m.cnt > 3 ? 3 : m.cnt;
      chk("rnd ex_valid", 128'(ex_valid), 128'(m.v));
      chk("rnd ex_op_a", 128'(ex_op_a), 128'(m.a));
      chk("rnd ex_op_b", 128'(ex_op_b), 128'(m.b));
      chk("rnd fields", 128'({ex_pc, ex_ctrl, ex_imm, ex_dst, ex_reg_w_en, ex_is_load}),
          128'({m.pc, m.ctrl, m.imm, m.dst, m.w, m.ld}));
      chk("rnd bubble_cnt", 128'(bubble_cnt), 128'(c16));
      chk("rnd w2 outputs",
          128'({ex_valid2, ex_op_a2, ex_op_b2, ex_pc2, ex_ctrl2, ex_dst2, ex_reg_w_en2, ex_is_load2}),
          128'({m.v, m.a, m.b, m.pc, m.ctrl, m.dst, m.w, m.ld}));
      chk("rnd w2 imm_cnt", 128'({ex_imm2, bubble_cnt2}), 128'({m.imm, 2'(c2)}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
